clock_timekeeper: RTL and testbench

Free-running time-of-day counter for the digital clock, on the receiving side of the time-setting block. It divides the 100 MHz system clock down to a 1 Hz tick and keeps hours/minutes/seconds. It freezes while set mode is active and loads the edited set values when set mode is exited. Its `seconds`/`minutes`/`hours` outputs feed back to the setting block and to the display path.

---
 rtl/clock_timekeeper.sv | 121 ++++++++++++
 tb/tb_clock_timekeeper.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clock_timekeeper.sv
// clock_timekeeper: 1 Hz time-of-day counter. It freezes while set mode is
// active and loads the edited time, after range checks, when set mode is left.
module clock_timekeeper #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set_mod,
  input  logic signed [32:0] set_hours,
  input  logic signed [32:0] set_minutes,
  input  logic signed [32:0] set_seconds,
  output logic [5:0]         seconds,
  output logic [5:0]         minutes,
  output logic [5:0]         hours,
  output logic               sec_tick,
  output logic               day_wrap,
  output logic               load_done,
  output logic               load_err
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  // Full-width signed range check so negative or oversized values are rejected.
  function automatic logic in_range(input logic signed [32:0] v,
                                    input logic signed [32:0] hi);
    return (v >= 33'sd0) && (v <= hi);
  endfunction

  logic [DIV_W-1:0] div_cnt_r, div_nxt_s;
  logic             set_mod_d_r;
  logic [5:0]       sec_r, min_r, hour_r;
  logic [5:0]       sec_nxt_s, min_nxt_s, hour_nxt_s;
  logic             sec_tick_r, day_wrap_r, load_done_r, load_err_r;
  logic             tick_s, wrap_s, done_s, err_s, set_valid_s;

  assign set_valid_s = in_range(set_seconds, 33'sd59) &&
                       in_range(set_minutes, 33'sd59) &&
                       in_range(set_hours,   33'sd23);

  // Next-state: freeze, load on set-mode exit, or prescale and advance.
  always_comb begin
    div_nxt_s  = div_cnt_r;
    sec_nxt_s  = sec_r;
    min_nxt_s  = min_r;
    hour_nxt_s = hour_r;
    tick_s     = 1'b0;
    wrap_s     = 1'b0;
    done_s     = 1'b0;
    err_s      = 1'b0;
    if (set_mod) begin
      div_nxt_s = '0;
    end else if (set_mod_d_r) begin
      // Load edge: the prescaler sits at 0 here, so no tick can coincide.
      div_nxt_s = '0;
      if (set_valid_s) begin
        sec_nxt_s  = set_seconds[5:0];
        min_nxt_s  = set_minutes[5:0];
        hour_nxt_s = set_hours[5:0];
        done_s     = 1'b1;
      end else begin
        err_s      = 1'b1;
      end
    end else if (div_cnt_r == DIV_LAST) begin
      div_nxt_s = '0;
      tick_s    = 1'b1;
      if (sec_r == 6'd59) begin
        sec_nxt_s = 6'd0;
        if (min_r == 6'd59) begin
          min_nxt_s = 6'd0;
          if (hour_r == 6'd23) begin
            hour_nxt_s = 6'd0;
            wrap_s     = 1'b1;
          end else begin
            hour_nxt_s = hour_r + 6'd1;
          end
        end else begin
          min_nxt_s = min_r + 6'd1;
        end
      end else begin
        sec_nxt_s = sec_r + 6'd1;
      end
    end else begin
      div_nxt_s = div_cnt_r + DIV_W'(1);
    end
  end

  // State and registered pulse outputs; reset overrides tick and load.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r   <= '0;
      set_mod_d_r <= 1'b0;
      sec_r       <= 6'd0;
      min_r       <= 6'd0;
      hour_r      <= 6'd0;
      sec_tick_r  <= 1'b0;
      day_wrap_r  <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      div_cnt_r   <= div_nxt_s;
      set_mod_d_r <= set_mod;
      sec_r       <= sec_nxt_s;
      min_r       <= min_nxt_s;
      hour_r      <= hour_nxt_s;
      sec_tick_r  <= tick_s;
      day_wrap_r  <= wrap_s;
      load_done_r <= done_s;
      load_err_r  <= err_s;
    end
  end

  assign seconds   = sec_r;
  assign minutes   = min_r;
  assign hours     = hour_r;
  assign sec_tick  = sec_tick_r;
  assign day_wrap  = day_wrap_r;
  assign load_done = load_done_r;
  assign load_err  = load_err_r;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Scoreboard bench for clock_timekeeper at TICK_DIV=4: stimulus queues the
// expected pulse events (cycle, flags, time) and a negedge monitor checks them.
module tb_clock_timekeeper;

  typedef struct packed {
    int unsigned cyc;
    logic        tick;
    logic        wrap;
    logic        done;
    logic        err;
    logic [5:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
  } ev_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               set_mod = 1'b0;
  logic signed [32:0] set_hours = 33'sd0;
  logic signed [32:0] set_minutes = 33'sd0;
  logic signed [32:0] set_seconds = 33'sd0;
  logic [5:0]         seconds, minutes, hours;
  logic               sec_tick, day_wrap, load_done, load_err;

  ev_t         sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int unsigned t0;

  clock_timekeeper #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .set_mod(set_mod),
    .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .sec_tick(sec_tick), .day_wrap(day_wrap),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Monitor: every pulse the DUT shows must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t act, exp_e;
    if (sec_tick | day_wrap | load_done | load_err) begin
      act = '{cyc: cyc, tick: sec_tick, wrap: day_wrap, done: load_done,
              err: load_err, h: hours, m: minutes, s: seconds};
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_event cyc=%0d tick=%b wrap=%b done=%b err=%b time=%0d:%0d:%0d required: no event",
                 cyc, sec_tick, day_wrap, load_done, load_err, hours, minutes, seconds);
      end else begin
        exp_e = sb.pop_front();
        if (act === exp_e) n_pass++;
        else $display("FAIL event got cyc=%0d t/w/d/e=%b%b%b%b %0d:%0d:%0d required cyc=%0d t/w/d/e=%b%b%b%b %0d:%0d:%0d",
                      act.cyc, act.tick, act.wrap, act.done, act.err, act.h, act.m, act.s,
                      exp_e.cyc, exp_e.tick, exp_e.wrap, exp_e.done, exp_e.err, exp_e.h, exp_e.m, exp_e.s);
      end
    end
  end

  // Watchdog bounds the run.
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required: finish before timeout", cyc);
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s got %0d required %0d", name, act, exp_v);
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, "_h"}, int'(hours), h);
    chk({name, "_m"}, int'(minutes), m);
    chk({name, "_s"}, int'(seconds), s);
  endtask

  task automatic push(input int unsigned c, input logic tk, input logic wr,
                      input logic dn, input logic er,
                      input int h, input int m, input int s);
    sb.push_back('{cyc: c, tick: tk, wrap: wr, done: dn, err: er,
                   h: 6'(h), m: 6'(m), s: 6'(s)});
  endtask

  // Hold set mode for len cycles, drop it and expect the load on the next edge.
  task automatic set_exit(input int len, input int sh, input int sm, input int ss,
                          input logic ok, input int eh, input int em, input int es);
    set_hours   = 33'(sh);
    set_minutes = 33'(sm);
    set_seconds = 33'(ss);
    set_mod = 1'b1;
    step(len);
    set_mod = 1'b0;
    push(cyc + 32'd1, 1'b0, 1'b0, ok, ~ok, eh, em, es);
    step(1);
    set_hours   = 33'sd5;
    set_minutes = 33'sd77;
    set_seconds = -33'sd9;
  endtask

  initial begin
    // 1. reset and count
    step(3);
    chk_time("reset", 0, 0, 0);
    chk("reset_tick", int'(sec_tick), 0);
    reset = 1'b0;
    t0 = cyc;
    for (int k = 1; k <= 4; k++) push(t0 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, k);
    step(16);
    chk("count_sec", int'(seconds), 4);

    // 2. carries and day rollover
    set_exit(1, 0, 0, 58, 1'b1, 0, 0, 58);
    t0 = cyc;
    push(t0 + 32'd4,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 59);
    push(t0 + 32'd8,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 0);
    push(t0 + 32'd12, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1);
    step(12);
    set_exit(1, 23, 59, 59, 1'b1, 23, 59, 59);
    push(cyc + 32'd4, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(4);

    // 3. freeze for 20 cycles, then valid load
    set_exit(1, 12, 34, 55, 1'b1, 12, 34, 55);
    push(cyc + 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 12, 34, 56);
    step(4);
    set_hours = 33'sd7; set_minutes = 33'sd8; set_seconds = 33'sd9;
    set_mod = 1'b1;
    step(20);
    chk_time("freeze", 12, 34, 56);
    set_mod = 1'b0;
    push(cyc + 32'd1, 1'b0, 1'b0, 1'b1, 1'b0, 7, 8, 9);
    step(1);
    set_hours = 33'sd30;
    push(cyc + 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 7, 8, 10);
    step(4);

    // 4. invalid loads leave time unchanged
    set_exit(1, 24, 8, 10, 1'b0, 7, 8, 10);
    set_exit(1, 7, 8, -1, 1'b0, 7, 8, 10);
    set_exit(1, 7, 60, 10, 1'b0, 7, 8, 10);
    push(cyc + 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 7, 8, 11);
    step(4);

    // 5a. reset on the same edge as the set-mode fall
    set_hours = 33'sd10; set_minutes = 33'sd10; set_seconds = 33'sd10;
    set_mod = 1'b1;
    step(2);
    set_mod = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_time("rst_load", 0, 0, 0);
    chk("rst_load_done", int'(load_done), 0);
    push(cyc + 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1);
    step(4);
    // 5b. reset with the prescaler at 2
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_time("rst_mid", 0, 0, 0);
    push(cyc + 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1);
    step(4);

    // 6. single-cycle set pulse
    set_exit(1, 1, 2, 3, 1'b1, 1, 2, 3);
    push(cyc + 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1, 2, 4);
    step(4);

    step(3);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
